closest_hit_resolver: RTL and testbench
=======================================

Name: closest_hit_resolver

Overview:
- Downstream consumer of the per-triangle ray/triangle intersection test in the coprocessor.
- Accepts one ray, then streams one {code, t} intersection result per triangle of the scene, and tracks the nearest valid hit.
- Computes the intersection point start + t*dir and hands {hit, index, t, point, ray} to the reflection/refraction stage through a valid/ready handshake.

Parameters:
- WIDTH, _WIDTH (32): fixed-point word width, from definitions_pack.
- BF, BF from definitions_pack (16): fractional bits of the fixed format.
- IDX_W, 16: triangle index/count width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ray_valid  in  1  ray offered
- ray_ready  out  1  resolver can accept a ray
- ray_in  in  6*WIDTH  ray struct {start.x,y,z, dir.x,y,z}
- trig_count  in  IDX_W  number of results to expect for this ray; sampled with the ray
- res_valid  in  1  intersection result offered
- res_ready  out  1  resolver accepts a result
- res_in  in  WIDTH+2  [WIDTH+1:WIDTH] code (2'b10 = hit), [WIDTH-1:0] t (signed fixed)
- out_valid  out  1  resolved hit available
- out_ready  in  1  downstream accepts
- out_hit  out  1  1 = at least one hit
- out_idx  out  IDX_W  index (0-based arrival order) of the nearest hit
- out_t  out  WIDTH  nearest t
- out_point  out  3*WIDTH  intersection point {x,y,z}
- out_ray  out  6*WIDTH  latched input ray (pass-through)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- On reset:
  - state = IDLE.
  - All registered outputs and internal registers are 0.
  - ray_ready, res_ready and out_valid are decoded from state: after reset ray_ready=1, res_ready=0, out_valid=0.
- IDLE:
  - ray_ready=1.
  - On ray_valid&ray_ready: latch ray_in and trig_count, clear cnt, best_valid and best_t/best_idx.
  - If trig_count==0, go to DONE with out_hit=0. Otherwise go to COLLECT.
- COLLECT:
  - res_ready=1.
  - Each accepted result (res_valid&res_ready) increments cnt.
  - A result is a hit only if code==2'b10; any other code is a miss.
  - On a hit with (!best_valid || t < best_t): update best_t, best_idx=cnt, best_valid=1. The compare is signed.
  - Equal t keeps the earlier index.
  - When the accepted result is the one with cnt==count-1:
    - If the hit/update condition also applies to it, it is applied in the same cycle.
    - Next state is MUL_X if the (updated) best_valid=1, else DONE.
- MUL_X / MUL_Y / MUL_Z, one cycle each, computing pt.c = start.c + fMul(best_t, dir.c):
  - fMul = signed WIDTHxWIDTH product, arithmetic shift right by BF, truncate to WIDTH.
  - The addition wraps modulo 2^WIDTH; there is no saturation.
- DONE:
  - out_valid=1; out_* are held stable until out_ready.
  - On out_valid&out_ready: go to IDLE; ray_ready=1 in the next cycle.
  - A miss reports out_hit=0, out_idx=0, out_t=0, out_point=0.
- Latency:
  - Hit: out_valid asserts 4 cycles after the clock edge accepting the last result.
  - Miss: 1 cycle after that edge.
  - trig_count==0: 1 cycle after ray accept.
- Throughput: one result per cycle in COLLECT. res_valid gaps are allowed. res_valid outside COLLECT is ignored (res_ready=0).
- ray_valid while not in IDLE is not accepted; the ray is held by the upstream.
- Reset mid-operation aborts the current ray immediately; partial state is discarded.
- cnt width is IDX_W; trig_count up to 2^IDX_W-1 is supported without wrap.

Decomposition:
- Use the existing definitions_pack: ray, point, vector, fixed typedefs, _WIDTH, BF. Use math_pack fMul.
- Add to light_pack:
  - hit code constant HIT_CODE = 2'b10.
  - resolver state enum {IDLE, COLLECT, MUL_X, MUL_Y, MUL_Z, DONE}.
- One sub-module: fixed_mac_unit, combinational a + fMul(b, c). It is shared across the three MUL states through a mux on the axis.

Test Plan:
- WIDTH=32, BF=16. Ray start (0,0,0), dir (0,0,0x00010000), trig_count=3, results {00,-}, {10,0x00018000}, {10,0x00020000} -> out_hit=1, out_idx=1, out_t=0x00018000, out_point=(0,0,0x00018000), out_valid 4 cycles after last accept.
- trig_count=2, both codes 2'b00 -> out_hit=0, all data 0, out_valid 1 cycle after last accept.
- trig_count=0 -> DONE 1 cycle after ray accept, out_hit=0, res_ready never asserted.
- Equal t tie: results {10,0x00010000} at idx 0 and idx 2 -> out_idx=0. Also hold out_ready=0 for 5 cycles -> outputs stable, ray_ready=0 throughout.
- Start (0x00010000, 0xFFFF0000, 0), dir (0x00008000, 0, 0xFFFF0000), t=0x00020000 -> point (0x00020000, 0xFFFF0000, 0xFFFE0000).
- Assert rst_n=0 mid-COLLECT after 2 of 4 results -> outputs 0 immediately, ray_ready=1 after release. A new ray then resolves independently of the aborted one.

Source files
------------

// File: rtl/closest_hit_resolver_pkg.sv
// Shared types and constants for the closest-hit resolver: fixed-point format,
// ray/vector structs, resolver state encoding and the fixed-point multiply.
package closest_hit_resolver_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned BF    = 16;
  localparam int unsigned IDX_W = 16;

  localparam logic [1:0] HIT_CODE = 2'b10;

  typedef logic signed [WIDTH-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  typedef struct packed {
    vec3_t start;
    vec3_t dir;
  } ray_t;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    MUL_X,
    MUL_Y,
    MUL_Z,
    DONE
  } state_t;

  // Full-width signed product, arithmetic shift back to the fixed format, truncate.
  function automatic fixed_t fmul(input fixed_t a, input fixed_t b);
    logic signed [2*WIDTH-1:0] prod;
    prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    return fixed_t'(prod >>> BF);
  endfunction

endpackage

// File: rtl/closest_hit_resolver_mac.sv
// Combinational fixed-point multiply-accumulate: y = a + fmul(b, c), wrapping.
module fixed_mac_unit
  import closest_hit_resolver_pkg::*;
(
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  output logic signed [WIDTH-1:0] y
);

  assign y = a + fmul(b, c);

endmodule

// File: rtl/closest_hit_resolver.sv
// Tracks the nearest valid hit over a stream of per-triangle results for one ray,
// then evaluates start + t*dir one axis per cycle on a shared MAC.
module closest_hit_resolver
  import closest_hit_resolver_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ray_valid,
  output logic                 ray_ready,
  input  logic [6*WIDTH-1:0]   ray_in,
  input  logic [IDX_W-1:0]     trig_count,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [WIDTH+1:0]     res_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_hit,
  output logic [IDX_W-1:0]     out_idx,
  output logic [WIDTH-1:0]     out_t,
  output logic [3*WIDTH-1:0]   out_point,
  output logic [6*WIDTH-1:0]   out_ray
);

  state_t           state_q, state_d;
  ray_t             ray_q;
  logic [IDX_W-1:0] count_q, cnt_q, best_idx_q;
  logic             best_valid_q;
  fixed_t           best_t_q;
  vec3_t            point_q;

  fixed_t res_t;
  logic   is_hit, take, last;
  fixed_t mac_a, mac_c, mac_y;

  assign res_t  = res_in[WIDTH-1:0];
  assign is_hit = (res_in[WIDTH+1:WIDTH] == HIT_CODE);
  assign take   = is_hit && (!best_valid_q || (res_t < best_t_q));
  assign last   = (cnt_q == count_q - IDX_W'(1));

  always_comb begin
    mac_a = ray_q.start.x;
    mac_c = ray_q.dir.x;
    case (state_q)
      MUL_Y: begin
        mac_a = ray_q.start.y;
        mac_c = ray_q.dir.y;
      end
      MUL_Z: begin
        mac_a = ray_q.start.z;
        mac_c = ray_q.dir.z;
      end
      default: ;
    endcase
  end

  fixed_mac_unit u_mac (
    .a (mac_a),
    .b (best_t_q),
    .c (mac_c),
    .y (mac_y)
  );

  always_comb begin
    state_d   = state_q;
    ray_ready = (state_q == IDLE);
    res_ready = (state_q == COLLECT);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE:    if (ray_valid) state_d = (trig_count == '0) ? DONE : COLLECT;
      // The final result's own update is folded into the exit decision.
      COLLECT: if (res_valid && last) state_d = (best_valid_q || take) ? MUL_X : DONE;
      MUL_X:   state_d = MUL_Y;
      MUL_Y:   state_d = MUL_Z;
      MUL_Z:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ray_q        <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
      best_t_q     <= '0;
      point_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (ray_valid) begin
          ray_q        <= ray_t'(ray_in);
          count_q      <= trig_count;
          cnt_q        <= '0;
          best_idx_q   <= '0;
          best_valid_q <= 1'b0;
          best_t_q     <= '0;
          point_q      <= '0;
        end
        COLLECT: if (res_valid) begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (take) begin
            best_t_q     <= res_t;
            best_idx_q   <= cnt_q;
            best_valid_q <= 1'b1;
          end
        end
        MUL_X:   point_q.x <= mac_y;
        MUL_Y:   point_q.y <= mac_y;
        MUL_Z:   point_q.z <= mac_y;
        default: ;
      endcase
    end
  end

  assign out_hit   = best_valid_q;
  assign out_idx   = best_idx_q;
  assign out_t     = best_t_q;
  assign out_point = point_q;
  assign out_ray   = ray_q;

endmodule

// File: tb/tb_closest_hit_resolver.sv
// Self-checking bench for closest_hit_resolver: directed table, reset abort and
// randomized rays checked against a behavioural nearest-hit model.
module tb_closest_hit_resolver;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ray_valid;
  logic         ray_ready;
  logic [191:0] ray_in;
  logic [15:0]  trig_count;
  logic         res_valid;
  logic         res_ready;
  logic [33:0]  res_in;
  logic         out_valid;
  logic         out_ready;
  logic         out_hit;
  logic [15:0]  out_idx;
  logic [31:0]  out_t;
  logic [95:0]  out_point;
  logic [191:0] out_ray;

  int checks = 0;
  int errors = 0;

  logic [1:0]  r_code[16];
  logic [31:0] r_t[16];

  always #5 clk = ~clk;

  closest_hit_resolver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ray_valid  (ray_valid),
    .ray_ready  (ray_ready),
    .ray_in     (ray_in),
    .trig_count (trig_count),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_in     (res_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hit    (out_hit),
    .out_idx    (out_idx),
    .out_t      (out_t),
    .out_point  (out_point),
    .out_ray    (out_ray)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ray_ready();
    int k = 0;
    while (!ray_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ray_ready_wait", 192'(ray_ready), 192'(1));
  endtask

  // Offer one ray and its results, then check latency, outputs, hold and release.
  task automatic run_ray(input logic [191:0] ray, input int n, input int gap, input int hold,
                         input logic e_hit, input logic [15:0] e_idx, input logic [31:0] e_t,
                         input logic [95:0] e_pt, input int e_lat);
    int k;
    wait_ray_ready();
    ray_valid  = 1'b1;
    ray_in     = ray;
    trig_count = 16'(n);
    @(negedge clk);
    ray_valid = 1'b0;
    if (n == 0) check("res_ready_zero", 192'(res_ready), 192'(0));
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        res_valid = 1'b0;
        @(negedge clk);
      end
      check("res_ready", 192'(res_ready), 192'(1));
      res_valid = 1'b1;
      res_in    = {r_code[i], r_t[i]};
      @(negedge clk);
    end
    res_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("latency", 192'(k), 192'(e_lat));
    check("out_hit", 192'(out_hit), 192'(e_hit));
    check("out_idx", 192'(out_idx), 192'(e_idx));
    check("out_t", 192'(out_t), 192'(e_t));
    check("out_point", 192'(out_point), 192'(e_pt));
    check("out_ray", out_ray, ray);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 192'(out_valid), 192'(1));
      check("hold_ray_ready", 192'(ray_ready), 192'(0));
      check("hold_data", {out_hit, out_idx, out_t, out_point}, {e_hit, e_idx, e_t, e_pt});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 192'(out_valid), 192'(0));
    check("release_ray_ready", 192'(ray_ready), 192'(1));
  endtask

  // Reference: nearest signed t among code==2'b10 results, earliest on ties.
  function automatic logic [31:0] ref_axis(input logic [31:0] s, input logic [31:0] t, input logic [31:0] d);
    longint p;
    logic [31:0] lo;
    p  = longint'(int'(t)) * longint'(int'(d));
    p  = p >>> 16;
    lo = p[31:0];
    return s + lo;
  endfunction

  typedef struct {
    logic [191:0] ray;
    int           n;
    logic [1:0]   code[4];
    logic [31:0]  t[4];
    int           hold;
    logic         hit;
    logic [15:0]  idx;
    logic [31:0]  t_exp;
    logic [95:0]  pt;
    int           lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ray_valid = 1'b0; ray_in = '0; trig_count = '0;
    res_valid = 1'b0; res_in = '0; out_ready = 1'b0;

    tbl[0] = '{ray: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00010000}, n: 3,
               code: '{2'b00, 2'b10, 2'b10, 2'b00}, t: '{32'h7, 32'h00018000, 32'h00020000, 32'h0},
               hold: 0, hit: 1'b1, idx: 16'd1, t_exp: 32'h00018000,
               pt: {32'h0, 32'h0, 32'h00018000}, lat: 4};
    tbl[1] = '{ray: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6}, n: 2,
               code: '{2'b00, 2'b00, 2'b00, 2'b00}, t: '{32'h100, 32'h200, 32'h0, 32'h0},
               hold: 0, hit: 1'b0, idx: 16'd0, t_exp: 32'h0, pt: 96'h0, lat: 1};
    tbl[2] = '{ray: {32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66}, n: 0,
               code: '{2'b00, 2'b00, 2'b00, 2'b00}, t: '{32'h0, 32'h0, 32'h0, 32'h0},
               hold: 1, hit: 1'b0, idx: 16'd0, t_exp: 32'h0, pt: 96'h0, lat: 1};
    tbl[3] = '{ray: {32'h0, 32'h0, 32'h0, 32'h00010000, 32'h00020000, 32'h0}, n: 3,
               code: '{2'b10, 2'b00, 2'b10, 2'b00}, t: '{32'h00010000, 32'h5, 32'h00010000, 32'h0},
               hold: 5, hit: 1'b1, idx: 16'd0, t_exp: 32'h00010000,
               pt: {32'h00010000, 32'h00020000, 32'h0}, lat: 4};
    tbl[4] = '{ray: {32'h00010000, 32'hFFFF0000, 32'h0, 32'h00008000, 32'h0, 32'hFFFF0000}, n: 1,
               code: '{2'b10, 2'b00, 2'b00, 2'b00}, t: '{32'h00020000, 32'h0, 32'h0, 32'h0},
               hold: 0, hit: 1'b1, idx: 16'd0, t_exp: 32'h00020000,
               pt: {32'h00020000, 32'hFFFF0000, 32'hFFFE0000}, lat: 4};
    tbl[5] = '{ray: {32'h0, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0}, n: 4,
               code: '{2'b10, 2'b10, 2'b01, 2'b10}, t: '{32'h5, 32'hFFFFFFF0, 32'hFFFFFF00, 32'h7FFFFFFF},
               hold: 2, hit: 1'b1, idx: 16'd1, t_exp: 32'hFFFFFFF0,
               pt: {32'hFFFFFFF0, 32'h0, 32'h0}, lat: 4};

    @(negedge clk);
    @(negedge clk);
    check("rst_ray_ready", 192'(ray_ready), 192'(1));
    check("rst_res_ready", 192'(res_ready), 192'(0));
    check("rst_out_valid", 192'(out_valid), 192'(0));
    check("rst_data", {out_hit, out_idx, out_t, out_point}, '0);
    check("rst_ray", out_ray, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        r_code[i] = tbl[v].code[i];
        r_t[i]    = tbl[v].t[i];
      end
      run_ray(tbl[v].ray, tbl[v].n, 0, tbl[v].hold, tbl[v].hit, tbl[v].idx,
              tbl[v].t_exp, tbl[v].pt, tbl[v].lat);
    end

    // Abort mid-collection, then resolve an unrelated ray.
    wait_ray_ready();
    ray_valid = 1'b1;
    ray_in = {32'h1, 32'h2, 32'h3, 32'h00010000, 32'h00010000, 32'h00010000};
    trig_count = 16'd4;
    @(negedge clk);
    ray_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      res_valid = 1'b1;
      res_in = {2'b10, 32'(32'h00030000 - i)};
      @(negedge clk);
    end
    res_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_data", {out_hit, out_idx, out_t, out_point}, '0);
    check("abort_ray", out_ray, '0);
    check("abort_valid", 192'(out_valid), 192'(0));
    check("abort_res_ready", 192'(res_ready), 192'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ray_ready", 192'(ray_ready), 192'(1));
    r_code[0] = 2'b00; r_t[0] = 32'h1;
    r_code[1] = 2'b01; r_t[1] = 32'h2;
    run_ray({32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF}, 2, 0, 0,
            1'b0, 16'd0, 32'h0, 96'h0, 1);

    for (int r = 0; r < 40; r++) begin
      logic [191:0] ray;
      int n, bv, bi, lat;
      int bt, ti;
      logic [31:0] px, py, pz;
      ray = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) begin
        r_code[i] = ($urandom_range(0, 2) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       r_t[i] = 32'h00010000;
          1:       r_t[i] = 32'hFFFF8000;
          default: r_t[i] = $urandom;
        endcase
      end
      bv = 0; bi = 0; bt = 0;
      for (int i = 0; i < n; i++) begin
        ti = int'(r_t[i]);
        if (r_code[i] == 2'b10 && (bv == 0 || ti < bt)) begin
          bv = 1; bt = ti; bi = i;
        end
      end
      if (bv != 0) begin
        px = ref_axis(ray[191:160], 32'(bt), ray[95:64]);
        py = ref_axis(ray[159:128], 32'(bt), ray[63:32]);
        pz = ref_axis(ray[127:96], 32'(bt), ray[31:0]);
        lat = 4;
      end else begin
        px = '0; py = '0; pz = '0;
        lat = 1;
      end
      run_ray(ray, n, 30, $urandom_range(0, 3), bv != 0, 16'(bi), 32'(bt),
              {px, py, pz}, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
